morse_transmitter: RTL and testbench

Morse code transmitter: the sending end of the keyed-line path whose receiving end qualifies key presses on `w`. It accepts a character code, looks up its ITU International Morse pattern, and drives `out` as an on/off keyed line with standard dot/dash/space timing. On the board it sits between the switch bank (character select plus a start key) and an LED or buzzer. Its `out` can also be looped back into the receiver-side FSM for self-test.

---
 rtl/morse_transmitter.sv | 159 +++++++++++++++
 tb/tb_morse_transmitter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_transmitter.sv
// Keyed-line Morse sender: ITU pattern ROM feeding a MARK/SPACE/GAP timer FSM.
// Define MORSE_DIGITS_EN to add digits 0-9 at codes 26-35.
module morse_transmitter #(
    parameter int UNIT_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] code,
    output logic       out,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int CW = $clog2(3 * UNIT_CYCLES + 1);
    localparam logic [CW-1:0] DOT_LOAD  = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] DASH_LOAD = CW'(3 * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]    pat, pat_n;
    logic [2:0]    len, len_n, idx, idx_n;
    logic          done_n, err_n;
    logic [7:0]    rom;
    logic [2:0]    rom_len;
    logic [4:0]    rom_pat;

    // {length, pattern left-aligned in 5 bits}; 1 = dash; length 0 marks an invalid code
    always_comb begin
        rom = 8'd0;
        case (code)
            6'd0:  rom = {3'd2, 5'b01000};
            6'd1:  rom = {3'd4, 5'b10000};
            6'd2:  rom = {3'd4, 5'b10100};
            6'd3:  rom = {3'd3, 5'b10000};
            6'd4:  rom = {3'd1, 5'b00000};
            6'd5:  rom = {3'd4, 5'b00100};
            6'd6:  rom = {3'd3, 5'b11000};
            6'd7:  rom = {3'd4, 5'b00000};
            6'd8:  rom = {3'd2, 5'b00000};
            6'd9:  rom = {3'd4, 5'b01110};
            6'd10: rom = {3'd3, 5'b10100};
            6'd11: rom = {3'd4, 5'b01000};
            6'd12: rom = {3'd2, 5'b11000};
            6'd13: rom = {3'd2, 5'b10000};
            6'd14: rom = {3'd3, 5'b11100};
            6'd15: rom = {3'd4, 5'b01100};
            6'd16: rom = {3'd4, 5'b11010};
            6'd17: rom = {3'd3, 5'b01000};
            6'd18: rom = {3'd3, 5'b00000};
            6'd19: rom = {3'd1, 5'b10000};
            6'd20: rom = {3'd3, 5'b00100};
            6'd21: rom = {3'd4, 5'b00010};
            6'd22: rom = {3'd3, 5'b01100};
            6'd23: rom = {3'd4, 5'b10010};
            6'd24: rom = {3'd4, 5'b10110};
            6'd25: rom = {3'd4, 5'b11000};
`ifdef MORSE_DIGITS_EN
            6'd26: rom = {3'd5, 5'b11111};
            6'd27: rom = {3'd5, 5'b01111};
            6'd28: rom = {3'd5, 5'b00111};
            6'd29: rom = {3'd5, 5'b00011};
            6'd30: rom = {3'd5, 5'b00001};
            6'd31: rom = {3'd5, 5'b00000};
            6'd32: rom = {3'd5, 5'b10000};
            6'd33: rom = {3'd5, 5'b11000};
            6'd34: rom = {3'd5, 5'b11100};
            6'd35: rom = {3'd5, 5'b11110};
`endif
            default: rom = 8'd0;
        endcase
    end

    assign rom_len = rom[7:5];
    assign rom_pat = rom[4:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            pat   <= '0;
            len   <= '0;
            idx   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pat   <= pat_n;
            len   <= len_n;
            idx   <= idx_n;
            done  <= done_n;
            err   <= err_n;
        end
    end

    // The pattern shifts left on each SPACE so pat[4] is always the current element.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pat_n   = pat;
        len_n   = len;
        idx_n   = idx;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (rom_len != 3'd0) begin
                        state_n = MARK;
                        pat_n   = rom_pat;
                        len_n   = rom_len;
                        idx_n   = 3'd0;
                        cnt_n   = rom_pat[4] ? DASH_LOAD : DOT_LOAD;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            MARK: begin
                if (cnt == '0) begin
                    if (idx == len - 3'd1) begin
                        state_n = GAP;
                        cnt_n   = DASH_LOAD;
                    end else begin
                        state_n = SPACE;
                        cnt_n   = DOT_LOAD;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            SPACE: begin
                if (cnt == '0) begin
                    state_n = MARK;
                    idx_n   = idx + 3'd1;
                    pat_n   = pat << 1;
                    cnt_n   = pat[3] ? DASH_LOAD : DOT_LOAD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign out  = (state == MARK);
    assign busy = (state != IDLE);
endmodule

// File: tb/tb_morse_transmitter.sv
// Bench for morse_transmitter: waveform model built from ITU dot/dash strings,
// per-character measurement table, directed corner sequences and random traffic.
module tb_morse_transmitter;
    localparam int U = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [5:0] code  = 6'd0;
    logic       out, busy, done, err;

    int checks = 0;
    int passes = 0;

    morse_transmitter #(.UNIT_CYCLES(U)) dut (
        .clock(clock), .reset(reset), .start(start), .code(code),
        .out(out), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    string morse_tab[36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
    };

    // Reference model: expected outputs for the current cycle plus the remaining waveform.
    logic eo = 0, eb = 0, ed = 0, ee = 0;
    bit   mq[$];

    function automatic bit code_ok(input logic [5:0] c);
`ifdef MORSE_DIGITS_EN
        return c < 36;
`else
        return c < 26;
`endif
    endfunction

    task automatic push_char(input int c);
        string s;
        s = morse_tab[c];
        for (int i = 0; i < s.len(); i++) begin
            repeat ((s[i] == "-") ? 3 * U : U) mq.push_back(1'b1);
            if (i != s.len() - 1) repeat (U) mq.push_back(1'b0);
        end
        repeat (3 * U) mq.push_back(1'b0);
    endtask

    task automatic model_edge();
        if (reset) begin
            mq.delete();
            {eo, eb, ed, ee} = 4'b0;
        end else if (eb) begin
            ee = 0;
            if (mq.size() > 0) begin
                eo = mq.pop_front(); eb = 1; ed = 0;
            end else begin
                eo = 0; eb = 0; ed = 1;
            end
        end else begin
            {eo, ed, ee} = 3'b0;
            if (start) begin
                if (code_ok(code)) begin
                    push_char(int'(code));
                    eo = mq.pop_front();
                    eb = 1;
                end else begin
                    ee = 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock: advance model on the edge, then compare DUT against it 2ns later.
    task automatic step();
        @(posedge clock);
        model_edge();
        #2;
        chk("model{out,busy,done,err}", {28'd0, out, busy, done, err}, {28'd0, eo, eb, ed, ee});
    endtask

    task automatic measure(input logic [5:0] c, output int bc, output int mk, output int dh,
                           output int er, output int dn, output bit to);
        int run;
        bc = 0; mk = 0; dh = 0; er = 0; dn = 0; run = 0; to = 1;
        code = c; start = 1; step(); start = 0;
        for (int k = 1; k <= 200; k++) begin
            if (k > 1) step();
            if (busy) bc++;
            if (err) er++;
            if (out) run++;
            else if (run > 0) begin
                mk++;
                if (run == 3 * U) dh++;
                run = 0;
            end
            if (done) begin dn++; to = 0; break; end
            if (k >= 3 && bc == 0) begin to = 0; break; end
        end
    endtask

    typedef struct {
        logic [5:0] c;
        int busy_cyc;
        int marks;
        int dashes;
        int errs;
    } vec_t;

    initial begin
        vec_t vt[$];
        int bc, mk, dh, er, dn;
        bit to, pd;
        logic [40:1] act_v, exp_v;

        vt.push_back('{6'd4,  8,  1, 0, 0});
        vt.push_back('{6'd0,  16, 2, 1, 0});
        vt.push_back('{6'd14, 28, 3, 3, 0});
        vt.push_back('{6'd16, 32, 4, 3, 0});
        vt.push_back('{6'd19, 12, 1, 1, 0});
        vt.push_back('{6'd18, 16, 3, 0, 0});
        vt.push_back('{6'd7,  20, 4, 0, 0});
        vt.push_back('{6'd25, 28, 4, 2, 0});
`ifdef MORSE_DIGITS_EN
        vt.push_back('{6'd30, 28, 5, 1, 0});
`else
        vt.push_back('{6'd30, 0,  0, 0, 1});
`endif
        vt.push_back('{6'd63, 0,  0, 0, 1});

        reset = 1;
        step();
        chk("reset_outputs", {28'd0, out, busy, done, err}, 32'd0);
        step();
        reset = 0;
        step();

        // E: mark 1-2, gap 3-8, done 9
        code = 6'd4; start = 1;
        for (int k = 1; k <= 9; k++) begin
            step();
            start = 0;
            chk($sformatf("E_cycle%0d", k), {28'd0, out, busy, done, err},
                {28'd0, 1'(k <= 2), 1'(k <= 8), 1'(k == 9), 1'b0});
        end
        step();

        // A: high 1-2, low 3-4, high 5-10, low 11-16, done 17
        code = 6'd0; start = 1; dn = 0;
        for (int k = 1; k <= 22; k++) begin
            step();
            start = 0;
            if (done) dn++;
            if (k <= 17)
                chk($sformatf("A_cycle%0d", k), {28'd0, out, busy, done, err},
                    {28'd0, 1'(k <= 2 || (k >= 5 && k <= 10)), 1'(k <= 16), 1'(k == 17), 1'b0});
        end
        chk("A_done_count", dn, 1);

        // Table of per-character measurements
        foreach (vt[i]) begin
            measure(vt[i].c, bc, mk, dh, er, dn, to);
            chk($sformatf("tbl%0d_timeout", vt[i].c), {31'd0, to}, 32'd0);
            chk($sformatf("tbl%0d_busy", vt[i].c), bc, vt[i].busy_cyc);
            chk($sformatf("tbl%0d_marks", vt[i].c), mk, vt[i].marks);
            chk($sformatf("tbl%0d_dashes", vt[i].c), dh, vt[i].dashes);
            chk($sformatf("tbl%0d_err", vt[i].c), er, vt[i].errs);
            chk($sformatf("tbl%0d_done", vt[i].c), dn, (vt[i].errs == 0) ? 1 : 0);
            step();
        end

        // Q with code toggling and start pulses mid-character
        code = 6'd16; start = 1; dn = 0; act_v = '0; exp_v = '0;
        for (int k = 1; k <= 40; k++) begin
            step();
            act_v[k] = out;
            exp_v[k] = (k <= 6) || (k >= 9 && k <= 14) || (k >= 17 && k <= 18) || (k >= 21 && k <= 26);
            if (done) begin
                dn++;
                chk("Q_done_cycle", k, 33);
            end
            code  = 6'($urandom_range(0, 63));
            start = (k == 5 || k == 9 || k == 12 || k == 20);
        end
        start = 0;
        chk("Q_pattern", act_v[32:1], exp_v[32:1]);
        chk("Q_done_count", dn, 1);

        // Reset during second mark of O (marks 1-6, 9-14)
        code = 6'd14; start = 1;
        for (int k = 1; k <= 10; k++) begin
            step();
            start = 0;
        end
        chk("O_second_mark", {31'd0, out}, 32'd1);
        reset = 1;
        step();
        chk("O_reset_outputs", {28'd0, out, busy, done, err}, 32'd0);
        reset = 0;
        measure(6'd4, bc, mk, dh, er, dn, to);
        chk("E_after_reset_busy", bc, 8);
        chk("E_after_reset_done", dn, 1);
        step();

        // Hold start: back-to-back E, each done followed by out=1
        code = 6'd4; start = 1; dn = 0; pd = 0;
        for (int k = 1; k <= 27; k++) begin
            step();
            if (pd) chk("b2b_mark_after_done", {31'd0, out}, 32'd1);
            if (done) dn++;
            pd = done;
        end
        chk("b2b_done_count", dn, 3);
        start = 0;
        repeat (12) step();

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            start = ($urandom_range(0, 3) == 0);
            code  = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 25));
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 0; start = 0;
        repeat (40) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
